seg_display_driver: RTL and testbench

- Downstream of the result selector: takes the 6-bit result magnitude and sign flag and drives the 3-digit, active-low seven-segment display (sign, tens, ones).
- Converts binary to BCD with a sequential double-dabble engine.
- Time-multiplexes the three anodes with a programmable refresh divider.
- Replaces the combinational digit selection in the top level.

---
 rtl/seg_display_if.sv | 12 +
 rtl/seg_display_driver.sv | 105 ++++++++++
 tb/tb_seg_display_driver.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seg_display_if.sv
// seg_display_if: display driver bus (value/sign/blank in, segments/anodes/busy out)
// Ports: value[5:0], is_negative, blank from the producer; seg[6:0], an[2:0], busy from the driver
interface seg_display_if;
  logic [5:0] value;
  logic       is_negative;
  logic       blank;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;
  modport master(output value, is_negative, blank, input seg, an, busy);
  modport slave(input value, is_negative, blank, output seg, an, busy);
endinterface

// File: rtl/seg_display_driver.sv
// seg_display_driver: 6-bit magnitude + sign to a 3-digit multiplexed active-low seven-segment display
// Ports: clk; reset (sync, active-low); bus (slave): value, is_negative, blank in; seg {g..a}, an {sign,tens,ones}, busy out
module seg_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W = $clog2(REFRESH_DIV)
) (
  input logic clk,
  input logic reset,
  seg_display_if.slave bus
);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t           state_q;
  logic             pending_q, neg_q, busy_q, wrap;
  logic [5:0]       val_q, sh_q, sh_d;
  logic [7:0]       bcd_q, bcd_d, adj;
  logic [2:0]       it_q, an_q, an_d;
  logic [6:0]       ones_q, tens_q, sign_q, seg_q, seg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: seg_code = 7'b1000000;
      4'd1: seg_code = 7'b1111001;
      4'd2: seg_code = 7'b0100100;
      4'd3: seg_code = 7'b0110000;
      4'd4: seg_code = 7'b0011001;
      4'd5: seg_code = 7'b0010010;
      4'd6: seg_code = 7'b0000010;
      4'd7: seg_code = 7'b1111000;
      4'd8: seg_code = 7'b0000000;
      4'd9: seg_code = 7'b0010000;
      default: seg_code = BLANK;
    endcase
  endfunction

  always_comb begin
    // one double-dabble step: add-3 correction, then shift the binary MSB into the BCD LSB
    adj = {bcd_q[7:4] >= 4'd5 ? bcd_q[7:4] + 4'd3 : bcd_q[7:4],
           bcd_q[3:0] >= 4'd5 ? bcd_q[3:0] + 4'd3 : bcd_q[3:0]};
    {bcd_d, sh_d} = {adj, sh_q} << 1;
    wrap = cnt_q == CNT_W'(REFRESH_DIV - 1);
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = !wrap ? idx_q : idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1;
    seg_d = idx_q == 2'd0 ? ones_q : idx_q == 2'd1 ? tens_q : sign_q;
    an_d = bus.blank ? 3'b111 : ~(3'b001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b1;
      busy_q    <= 1'b0;
      val_q     <= '0;
      neg_q     <= 1'b0;
      bcd_q     <= '0;
      sh_q      <= '0;
      it_q      <= '0;
      ones_q    <= BLANK;
      tens_q    <= BLANK;
      sign_q    <= BLANK;
      seg_q     <= BLANK;
      an_q      <= 3'b111;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      case (state_q)
        IDLE: if (pending_q || {bus.value, bus.is_negative} != {val_q, neg_q}) begin
          val_q     <= bus.value;
          neg_q     <= bus.is_negative;
          pending_q <= 1'b0;
          bcd_q     <= '0;
          sh_q      <= bus.value;
          it_q      <= '0;
          busy_q    <= 1'b1;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          sh_q  <= sh_d;
          it_q  <= it_q + 3'd1;
          if (it_q == 3'd5) state_q <= COMMIT;
        end
        COMMIT: begin
          ones_q  <= seg_code(bcd_q[3:0]);
          tens_q  <= bcd_q[7:4] == 4'd0 ? BLANK : seg_code(bcd_q[7:4]);
          sign_q  <= neg_q ? MINUS : BLANK;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver: directed checks of conversion, scan, blanking and reset
module tb_seg_display_driver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  localparam logic [6:0] BL = 7'b1111111, MI = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;

  seg_display_if bus();
  seg_display_driver #(.REFRESH_DIV(4)) dut(.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Collects one full scan frame starting at the first cycle of the ones window.
  task automatic observe_frame(output logic [6:0] o, t, s, output logic hold_ok, tmo);
    logic [2:0] prev;
    int n;
    hold_ok = 1'b1;
    prev = bus.an;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.an == 3'b110 && prev != 3'b110) break;
      prev = bus.an;
    end
    tmo = n == 60;
    o = bus.seg;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (bus.an !== 3'b110 || bus.seg !== o) hold_ok = 1'b0;
    end
    @(negedge clk);
    t = bus.seg;
    if (bus.an !== 3'b101) hold_ok = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (bus.an !== 3'b101 || bus.seg !== t) hold_ok = 1'b0;
    end
    @(negedge clk);
    s = bus.seg;
    if (bus.an !== 3'b011) hold_ok = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (bus.an !== 3'b011 || bus.seg !== s) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [6:0] o, t, s;
    logic h, tmo;
    int hi;
    bus.value = 6'd27;
    bus.is_negative = 1'b0;
    bus.blank = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.seg !== BL) begin fails++; $display("FAIL reset_seg got %b want %b", bus.seg, BL); end
    tests++; if (bus.an !== 3'b111) begin fails++; $display("FAIL reset_an got %b want 111", bus.an); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL first_busy got %b want 1", bus.busy); end
    hi = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      hi++;
    end
    tests++; if (hi != 7) begin fails++; $display("FAIL busy_len got %0d want 7", hi); end
    observe_frame(o, t, s, h, tmo);
    tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL r27_timeout got %b want 0", tmo); end
    tests++; if (o !== S7) begin fails++; $display("FAIL r27_ones got %b want %b", o, S7); end
    tests++; if (t !== S2) begin fails++; $display("FAIL r27_tens got %b want %b", t, S2); end
    tests++; if (s !== BL) begin fails++; $display("FAIL r27_sign got %b want %b", s, BL); end
    tests++; if (h !== 1'b1) begin fails++; $display("FAIL r27_hold got %b want 1", h); end
  endtask

  task automatic test_digits(input string name, input logic [5:0] v, input logic neg,
                             input logic [6:0] eo, et, es);
    logic [6:0] o, t, s;
    logic h, tmo;
    bus.value = v;
    bus.is_negative = neg;
    repeat (9) @(negedge clk);
    observe_frame(o, t, s, h, tmo);
    tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL %s_timeout got %b want 0", name, tmo); end
    tests++; if (o !== eo) begin fails++; $display("FAIL %s_ones got %b want %b", name, o, eo); end
    tests++; if (t !== et) begin fails++; $display("FAIL %s_tens got %b want %b", name, t, et); end
    tests++; if (s !== es) begin fails++; $display("FAIL %s_sign got %b want %b", name, s, es); end
    tests++; if (h !== 1'b1) begin fails++; $display("FAIL %s_hold got %b want 1", name, h); end
  endtask

  // Display shows 0 before; 12 then 9 are the only legal new digits.
  task automatic test_back_to_back();
    logic [19:0] seq;
    logic [6:0] o, t, s;
    logic h, tmo;
    int n, bad;
    bad = 0;
    seq = '0;
    bus.value = 6'd12;
    bus.is_negative = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) break;
    end
    tests++; if (n == 20) begin fails++; $display("FAIL b2b_start got timeout want busy"); end
    seq[0] = bus.busy;
    for (int i = 1; i < 20; i++) begin
      if (i == 3) bus.value = 6'd9;
      @(negedge clk);
      seq[i] = bus.busy;
      if (bus.an == 3'b110 && !(bus.seg == S0 || bus.seg == S2 || bus.seg == S9)) bad++;
      else if (bus.an == 3'b101 && !(bus.seg == BL || bus.seg == S1)) bad++;
      else if (bus.an == 3'b011 && bus.seg != BL) bad++;
      else if (!(bus.an == 3'b110 || bus.an == 3'b101 || bus.an == 3'b011)) bad++;
    end
    tests++; if (seq !== 20'h07F7F) begin fails++; $display("FAIL b2b_busy got %h want 07f7f", seq); end
    tests++; if (bad != 0) begin fails++; $display("FAIL b2b_garbage got %0d want 0", bad); end
    observe_frame(o, t, s, h, tmo);
    tests++; if (o !== S9) begin fails++; $display("FAIL b2b_ones got %b want %b", o, S9); end
    tests++; if (t !== BL) begin fails++; $display("FAIL b2b_tens got %b want %b", t, BL); end
    tests++; if (s !== BL || tmo !== 1'b0) begin fails++; $display("FAIL b2b_sign got %b/%b want %b/0", s, tmo, BL); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] o, t, s;
    logic h, tmo;
    int n;
    bus.value = 6'd45;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) break;
    end
    tests++; if (n == 20) begin fails++; $display("FAIL rmid_start got timeout want busy"); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tests++; if (bus.seg !== BL) begin fails++; $display("FAIL rmid_seg got %b want %b", bus.seg, BL); end
    tests++; if (bus.an !== 3'b111) begin fails++; $display("FAIL rmid_an got %b want 111", bus.an); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
    @(negedge clk);
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rmid_restart got %b want 1", bus.busy); end
    repeat (8) @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rmid_done got %b want 0", bus.busy); end
    observe_frame(o, t, s, h, tmo);
    tests++; if (o !== S5) begin fails++; $display("FAIL rmid_ones got %b want %b", o, S5); end
    tests++; if (t !== S4) begin fails++; $display("FAIL rmid_tens got %b want %b", t, S4); end
    tests++; if (s !== BL || tmo !== 1'b0) begin fails++; $display("FAIL rmid_sign got %b/%b want %b/0", s, tmo, BL); end
  endtask

  task automatic test_blank();
    logic [6:0] prev, exp;
    int bad, chg;
    bad = 0;
    chg = 0;
    bus.blank = 1'b1;
    @(negedge clk);
    prev = bus.seg;
    if (bus.an !== 3'b111) bad++;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (bus.an !== 3'b111) bad++;
      if (bus.seg !== prev) chg++;
      prev = bus.seg;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL blank_an got %0d lit samples want 0", bad); end
    tests++; if (chg < 4) begin fails++; $display("FAIL blank_scan got %0d changes want >=4", chg); end
    bus.blank = 1'b0;
    @(negedge clk);
    exp = bus.an == 3'b110 ? S5 : bus.an == 3'b101 ? S4 : bus.an == 3'b011 ? BL : 7'bx;
    tests++; if (bus.an === 3'b111) begin fails++; $display("FAIL unblank_an got %b want one low", bus.an); end
    tests++; if (bus.seg !== exp) begin fails++; $display("FAIL unblank_seg got %b want %b", bus.seg, exp); end
  endtask

  initial begin
    test_reset();
    test_digits("neg5", 6'd5, 1'b1, S5, BL, MI);
    test_digits("v63", 6'd63, 1'b0, S3, S6, BL);
    test_digits("negzero", 6'd0, 1'b1, S0, BL, MI);
    test_digits("zero", 6'd0, 1'b0, S0, BL, BL);
    test_back_to_back();
    test_reset_mid();
    test_blank();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
